// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU constants for the hazard controller.
// Holds the front-end FSM encodings, the mult/div latency default and a control-bundle helper.
package pipe_hazard_ctrl_pkg;

  localparam int MD_LAT_DEFAULT = 16;
  localparam int MD_CNT_W       = 6;
  localparam int STALL_W        = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    REDIR = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
  } hz_ctrl_t;

  function automatic hz_ctrl_t mk_ctrl(input logic pc_we, input logic ifid_we,
                                       input logic ifid_flush, input logic idex_bubble);
    hz_ctrl_t c;
    c.pc_we       = pc_we;
    c.ifid_we     = ifid_we;
    c.ifid_flush  = ifid_flush;
    c.idex_bubble = idex_bubble;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: HI/LO stays busy for MD_LAT cycles after an issue.
module md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic busy
);

  logic [MD_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= MD_CNT_W'(MD_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - MD_CNT_W'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, taken-branch flushes and
// instruction-miss handling, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               id_reads_hilo,
  input  logic               md_start,
  input  logic               ex_memread,
  input  logic [4:0]         ex_rt,
  input  logic               branch_taken,
  input  logic               imem_ready,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               md_busy,
  output logic [1:0]         state,
  output logic [STALL_W-1:0] stall_cnt
);

  hz_state_e          r_state;
  hz_state_e          w_next_state;
  hz_ctrl_t           w_ctrl;
  logic               w_load_use;
  logic               w_md_hazard;
  logic               w_md_busy;
  logic               w_md_load;
  logic [STALL_W-1:0] r_stall_cnt;

  assign w_load_use  = ex_memread && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign w_md_hazard = w_md_busy && id_reads_hilo;

  // A mult/div only issues when the IF/ID instruction actually advances into EX.
  assign w_md_load = md_start && !w_ctrl.idex_bubble;

  md_busy_cnt #(
    .MD_LAT(MD_LAT)
  ) u_md_busy_cnt (
    .clk (clk),
    .clr (clr),
    .load(w_md_load),
    .busy(w_md_busy)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs depend only on inputs; the state register just remembers why fetch is waiting.
  always_comb begin
    w_next_state = r_state;
    w_ctrl       = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    if (clr) begin
      w_next_state = RUN;
      w_ctrl       = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b1);
    end else if (branch_taken) begin
      w_next_state = imem_ready ? RUN : REDIR;
      w_ctrl       = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b1);
    end else if (!imem_ready) begin
      w_next_state = (r_state == RUN) ? IMISS : r_state;
      w_ctrl       = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
    end else begin
      w_next_state = RUN;
      if (w_md_hazard || w_load_use) begin
        w_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
    end else if (!w_ctrl.pc_we && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign pc_we       = w_ctrl.pc_we;
  assign ifid_we     = w_ctrl.ifid_we;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_bubble = w_ctrl.idex_bubble;
  assign md_busy     = w_md_busy;
  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-deadline reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 16;

  logic        clk;
  logic        clr;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_reads_hilo;
  logic        md_start;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        imem_ready;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        md_busy;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: HI/LO busy until a deadline cycle, mode 0/1/2 = run/miss/redirect.
  int cycleNum   = 0;
  int mdEndCycle = 0;
  int stallModel = 0;
  int modeModel  = 0;

  pipe_hazard_ctrl #(
    .MD_LAT(LAT)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_reads_hilo(id_reads_hilo),
    .md_start     (md_start),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .md_busy      (md_busy),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic runCycle(input string tag);
    logic       busy;
    logic       loadUse;
    logic       mdHaz;
    logic [3:0] ctl;
    int         nextMode;
    #1;
    if (clr) begin
      modeModel  = 0;
      mdEndCycle = 0;
      stallModel = 0;
    end
    busy    = (cycleNum < mdEndCycle);
    loadUse = ex_memread && (ex_rt != 0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mdHaz   = busy && id_reads_hilo;
    if (clr) begin
      ctl = 4'b0011; nextMode = 0;
    end else if (branch_taken) begin
      ctl = 4'b1111; nextMode = imem_ready ? 0 : 2;
    end else if (!imem_ready) begin
      ctl = 4'b0110; nextMode = (modeModel == 0) ? 1 : modeModel;
    end else begin
      nextMode = 0;
      ctl = (mdHaz || loadUse) ? 4'b0001 : 4'b1100;
    end
    checkOutput({tag, ".pc_we"},       16'(pc_we),       16'(ctl[3]));
    checkOutput({tag, ".ifid_we"},     16'(ifid_we),     16'(ctl[2]));
    checkOutput({tag, ".ifid_flush"},  16'(ifid_flush),  16'(ctl[1]));
    checkOutput({tag, ".idex_bubble"}, 16'(idex_bubble), 16'(ctl[0]));
    checkOutput({tag, ".state"},       16'(state),       16'(modeModel));
    checkOutput({tag, ".md_busy"},     16'(md_busy),     16'(busy));
    checkOutput({tag, ".stall_cnt"},   stall_cnt,        16'(stallModel));
    if (!clr) begin
      if (md_start && !ctl[0]) mdEndCycle = cycleNum + 1 + LAT;
      if (!ctl[3] && stallModel < 65535) stallModel++;
      modeModel = nextMode;
    end
    @(posedge clk);
    cycleNum++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic readsHilo, input logic mdStart,
                               input logic memRead, input logic [4:0] exRt,
                               input logic br, input logic ready);
    id_rs         = rs;
    id_rt         = rt;
    id_uses_rt    = usesRt;
    id_reads_hilo = readsHilo;
    md_start      = mdStart;
    ex_memread    = memRead;
    ex_rt         = exRt;
    branch_taken  = br;
    imem_ready    = ready;
    runCycle(tag);
  endtask

  task automatic nop(input string tag);
    applyStimulus(tag, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] s0;
    clr = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_reads_hilo = 1'b0; md_start = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; branch_taken = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    applyStimulus("reset", 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    clr = 1'b0;
    nop("post_reset");

    // Load-use on rs, then on rt, and the r0 exemption
    s0 = stall_cnt;
    applyStimulus("lu_rs", 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    applyStimulus("lu_after", 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1);
    checkOutput("lu_stall_delta", stall_cnt - s0, 16'd1);
    applyStimulus("lu_r0", 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    applyStimulus("lu_rt", 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    applyStimulus("lu_rt_unused", 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);

    // Taken branch with a ready fetch
    applyStimulus("br", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("br_state", 16'(state), 16'd0);
    nop("br_after");

    // Redirect whose target fetch misses for three cycles
    applyStimulus("redir_br", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("redir_state", 16'(state), 16'd2);
    for (int k = 0; k < 3; k++)
      applyStimulus("redir_wait", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    nop("redir_ready");
    checkOutput("redir_done_state", 16'(state), 16'd0);

    // mult at cycle 0, mflo at cycle 3 stalls until HI/LO frees
    applyStimulus("md_issue", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    nop("md_c1");
    nop("md_c2");
    s0 = stall_cnt;
    for (int k = 3; k <= LAT + 1; k++)
      applyStimulus("md_mflo", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("md_stall_delta", stall_cnt - s0, 16'(LAT - 2));

    // Back-to-back mult: the second waits for the first
    applyStimulus("md_b2b_a", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus("md_b2b_b", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < LAT + 2; k++) nop("md_drain");

    // Branch outranks simultaneous load-use and HI/LO hazards
    applyStimulus("prio_issue", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus("prio_all", 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    nop("prio_after");
    checkOutput("prio_md_busy", 16'(md_busy), 16'd1);

    // Reset asserted mid-IMISS while HI/LO is busy
    applyStimulus("rst_issue", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus("rst_miss1", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus("rst_miss2", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    clr = 1'b1;
    applyStimulus("rst_mid", 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    clr = 1'b0;
    nop("rst_release");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic br;
      logic rdy;
      logic ms;
      logic rh;
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      ms  = !br && ($urandom_range(0, 7) == 0);
      rh  = ms || ($urandom_range(0, 4) == 0);
      clr = ($urandom_range(0, 59) == 0);
      applyStimulus("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), rh, ms, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), br, rdy);
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 16; cycles a mult/div occupies HI/LO, legal range 2..63.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port clr, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port id_rs, input, 5: rs field of the instruction held in IF/ID.
REQ-005 SHALL have port id_rt, input, 5: rt field of the IF/ID instruction.
REQ-006 SHALL have port id_uses_rt, input, 1: IF/ID instruction reads rt.
REQ-007 SHALL have port id_reads_hilo, input, 1: IF/ID instruction is mfhi, mflo, mult or div.
REQ-008 SHALL have port md_start, input, 1: IF/ID instruction is mult/div and issues this cycle.
REQ-009 SHALL have port ex_memread, input, 1: ID/EX instruction is a load.
REQ-010 SHALL have port ex_rt, input, 5: load destination in ID/EX.
REQ-011 SHALL have port branch_taken, input, 1: branch/jump resolved taken in EX.
REQ-012 SHALL have port imem_ready, input, 1: instruction memory returns valid data this cycle.
REQ-013 SHALL have outputs pc_we, ifid_we, ifid_flush and idex_bubble, each 1 bit: PC write enable, IF/ID write enable, load NOP into IF/ID, and insert NOP into ID/EX.
REQ-014 SHALL have output md_busy, 1 bit: HI/LO result pending.
REQ-015 SHALL have output state, 2 bits: FSM state, where RUN=0, IMISS=1, REDIR=2 and 3 is unused.
REQ-016 SHALL have output stall_cnt, 16 bits: saturating count of stall cycles.

Function
REQ-017 SHALL compute load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
REQ-018 SHALL compute md_hazard = md_busy & id_reads_hilo.
REQ-019 SHALL drive all four control outputs combinationally, within the same cycle, from state and inputs, using the priority branch_taken > imem_ready==0 > md_hazard > load_use.
REQ-020 SHALL, when branch_taken=1, drive pc_we=1, ifid_we=1, ifid_flush=1 and idex_bubble=1, with next state REDIR if imem_ready=0 and RUN otherwise.
REQ-021 SHALL, when branch_taken=0 and imem_ready=0, drive pc_we=0, ifid_we=1, ifid_flush=1 and idex_bubble=0, and enter IMISS from RUN; the downstream stages keep draining.
REQ-022 SHALL, on a md_hazard or load_use stall, drive pc_we=0, ifid_we=0, ifid_flush=0 and idex_bubble=1.
REQ-023 SHALL, with no hazard in RUN, drive pc_we=1, ifid_we=1, ifid_flush=0 and idex_bubble=0.
REQ-024 SHALL keep IMISS and REDIR outputs as in REQ-021 while imem_ready=0, and return to RUN on the cycle imem_ready=1, applying RUN rules that same cycle.
REQ-025 SHALL treat a branch_taken in IMISS or REDIR per REQ-020, so the newest target wins.
REQ-026 SHALL, in REDIR, never let ifid_flush drop until the first post-redirect fetch is ready, so that wrong-path instructions never enter IF/ID.
REQ-027 SHALL use a 6-bit md counter that loads MD_LAT when md_start=1 and no stall is active, decrements when nonzero, and drives md_busy=(counter!=0).
REQ-028 SHALL ignore md_start while a stall per REQ-022 is active, because the issue is blocked.
REQ-029 SHALL, when md_start and md_busy are both 1, stall per REQ-018, with the counter continuing to decrement.
REQ-030 SHALL let a flush by branch_taken never cancel an already running md counter.
REQ-031 SHALL increment stall_cnt every cycle pc_we=0 and saturate it at 16'hFFFF without wrapping.

Reset
REQ-032 SHALL, while clr=1, immediately set state=RUN, md counter=0, md_busy=0 and stall_cnt=0.
REQ-033 SHALL, while clr=1, force pc_we=0, ifid_we=0, ifid_flush=1 and idex_bubble=1, regardless of the other inputs.
REQ-034 SHALL discard all pending state when clr asserts mid-stall, mid-redirect or mid-mult/div; the first cycle after release is RUN rules.

Structure
REQ-035 SHALL place the state encodings (RUN, IMISS, REDIR) and the MD_LAT default in the shared CPU constants header.
REQ-036 SHALL implement the md counter as sub-module md_busy_cnt, with ports clk, clr, load, and busy.
REQ-037 SHALL contain the FSM, the hazard compares and the stall counter in the top module.

Verification
REQ-038 SHALL cover load-use: ex_memread=1, ex_rt=5, id_rs=5 -> exactly 1 cycle with pc_we=0, ifid_we=0, idex_bubble=1, and with ex_rt=0 -> no stall.
REQ-039 SHALL cover branch: branch_taken=1, imem_ready=1 -> ifid_flush=1, idex_bubble=1, pc_we=1 for 1 cycle, then state=0.
REQ-040 SHALL cover redirect miss: branch_taken=1 with imem_ready=0 held for 3 cycles -> state=2, ifid_flush=1, pc_we=0 for 3 cycles, then RUN on ready.
REQ-041 SHALL cover mult/div: md_start at cycle 0 with MD_LAT=16, then mflo at cycle 3 -> stall through the cycle md_busy falls, then proceeds, and stall_cnt increases by the stalled cycles.
REQ-042 SHALL cover priority: load_use, md_hazard and branch_taken all active in one cycle -> branch behaviour only, and the md counter keeps counting.
REQ-043 SHALL cover reset: clr pulsed mid-IMISS with md_busy=1 -> state=0, md_busy=0, stall_cnt=0 asynchronously, and outputs per REQ-033 during clr.
